sram_wb_port: RTL



---
 rtl/sram_wb_port_if.sv | 25 ++
 rtl/sram_wb_port.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sram_wb_port_if.sv
// Wishbone B4 classic bus bundle between the peripheral interconnect and sram_wb_port.
// The master modport is the interconnect side; the slave modport is sram_wb_port.
interface sram_wb_port_if #(
  parameter int unsigned BYTE_COUNT   = 4,
  parameter int unsigned ADDRESS_SIZE = 9
);
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic [BYTE_COUNT-1:0]     wb_sel_i;
  logic [ADDRESS_SIZE+1:0]   wb_adr_i;
  logic [8*BYTE_COUNT-1:0]   wb_data_i;
  logic                      wb_ack_o;
  logic [8*BYTE_COUNT-1:0]   wb_data_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_data_o
  );
endinterface

// File: rtl/sram_wb_port.sv
// Wishbone classic slave driving the primary read/write port of an SRAM wrapper.
// Optional feature: SRAM_WB_PORT_WRITE_PROTECT_EN adds a writeProtect input that suppresses writes.
module sram_wb_port #(
  parameter int unsigned BYTE_COUNT   = 4,
  parameter int unsigned ADDRESS_SIZE = 9,
  parameter int unsigned READ_LATENCY = 1  // legal range 1..3
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SRAM_WB_PORT_WRITE_PROTECT_EN
  input  logic                    writeProtect,
`endif
  sram_wb_port_if.slave           wb,
  output logic                    primarySelect,
  output logic                    primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]   primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0] primaryAddress,
  output logic [8*BYTE_COUNT-1:0] primaryDataWrite,
  input  logic [8*BYTE_COUNT-1:0] primaryDataRead
);

  localparam logic [1:0] LatLoad = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic                      ack_q, ack_d;
  logic [8*BYTE_COUNT-1:0]   rdata_q, rdata_d;
  logic                      sel_q, sel_d;
  logic                      wen_q, wen_d;
  logic [BYTE_COUNT-1:0]     mask_q, mask_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic [8*BYTE_COUNT-1:0]   wdata_q, wdata_d;
  logic                      wp;
  logic                      unused_adr;

  // Byte offset bits are meaningless for a word-addressed SRAM.
  assign unused_adr = ^wb.wb_adr_i[1:0];

`ifdef SRAM_WB_PORT_WRITE_PROTECT_EN
  assign wp = writeProtect;
`else
  assign wp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    sel_d   = 1'b0;
    wen_d   = 1'b0;
    mask_d  = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          state_d = StIssue;
          we_d    = wb.wb_we_i;
          // A protected write still walks the FSM so it is acked on schedule.
          if (!(wb.wb_we_i && wp)) begin
            sel_d   = 1'b1;
            wen_d   = wb.wb_we_i;
            mask_d  = wb.wb_we_i ? wb.wb_sel_i : '0;
            addr_d  = wb.wb_adr_i[ADDRESS_SIZE+1:2];
            wdata_d = wb.wb_data_i;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StAck;
          ack_d   = 1'b1;
        end else begin
          state_d = StWait;
          cnt_d   = LatLoad;
        end
      end
      StWait: begin
        if (!wb.wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 2'd0) begin
          state_d = StAck;
          ack_d   = 1'b1;
          rdata_d = primaryDataRead;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck: begin
        // Ack is already on the bus this cycle; an abort here needs nothing extra.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      wen_q   <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb.wb_ack_o         = ack_q;
  assign wb.wb_data_o        = rdata_q;
  assign primarySelect       = sel_q;
  assign primaryWriteEnable  = wen_q;
  assign primaryWriteMask    = mask_q;
  assign primaryAddress      = addr_q;
  assign primaryDataWrite    = wdata_q;

endmodule
